// File: rtl/ff_stage_pkg.sv
// Shared constants and types for the credit-flow-controlled pipeline stage.
package ff_stage_pkg;

    localparam int unsigned PATH_WIDTH  = 64;
    localparam int unsigned DEF_DEPTH   = 2;
    localparam int unsigned DEF_CREDITS = 2;

    typedef logic [PATH_WIDTH-1:0] path_t;

endpackage

// File: rtl/ff_stage_fifo.sv
// Circular-buffer FIFO, DEPTH x WIDTH, with a separate occupancy count for full/empty.
module ff_stage_fifo
    import ff_stage_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned WIDTH = PATH_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign dout    = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    // A push into a full buffer is only accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clr) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = ptr_inc(wr_q);
            if (do_pop)  rd_d = ptr_inc(rd_q);
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/ff_stage.sv
// Credit-flow-controlled pipeline register stage: input FIFO, bypass mux,
// downstream credit counter and registered outputs.
module ff_stage
    import ff_stage_pkg::*;
#(
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned CREDITS = DEF_CREDITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic                  credit_in,
    input  logic [PATH_WIDTH-1:0] data_in,
    input  logic                  done,
    output logic                  credit_out,
    output logic [PATH_WIDTH-1:0] data_out,
    output logic                  valid_out
);

    localparam int unsigned CNT_W = $clog2(CREDITS + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    path_t            data_q, data_d;
    logic             valid_q, valid_d;
    logic             credit_q, credit_d;

    path_t fifo_dout, src_c;
    logic  fifo_empty, fifo_full;
    logic  send_c, bypass_c, fifo_push_c, fifo_pop_c;

    ff_stage_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PATH_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (!done),
        .push  (fifo_push_c),
        .pop   (fifo_pop_c),
        .din   (data_in),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Older FIFO data always wins; data_in only bypasses an empty FIFO.
    always_comb begin
        send_c      = done && (!fifo_empty || valid_in) && (cnt_q != '0);
        bypass_c    = send_c && fifo_empty;
        fifo_push_c = done && valid_in && !bypass_c;
        fifo_pop_c  = send_c && !fifo_empty;
        src_c       = fifo_empty ? data_in : fifo_dout;
    end

    always_comb begin
        cnt_d    = cnt_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        credit_d = 1'b0;
        if (!done) begin
            cnt_d  = CNT_W'(CREDITS);
            data_d = '0;
        end else begin
            if (send_c) begin
                data_d   = src_c;
                valid_d  = 1'b1;
                credit_d = 1'b1;
            end
            // Excess returned credits saturate at CREDITS.
            if (send_c && !credit_in)
                cnt_d = cnt_q - CNT_W'(1);
            else if (!send_c && credit_in && (cnt_q != CNT_W'(CREDITS)))
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= CNT_W'(CREDITS);
            data_q   <= '0;
            valid_q  <= 1'b0;
            credit_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            credit_q <= credit_d;
        end
    end

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign credit_out = credit_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst && fifo_push_c && fifo_full && !fifo_pop_c)
            $error("ff_stage: push into full FIFO dropped (upstream credit violation)");
    end
`endif

endmodule

// File: tb/tb_ff_stage.sv
// Bench for ff_stage: directed scenarios plus credit-respecting random traffic,
// checked every cycle against a queue-based behavioural model.
module tb_ff_stage;
    import ff_stage_pkg::*;

    localparam int unsigned DEPTH   = 2;
    localparam int unsigned CREDITS = 2;

    typedef logic [PATH_WIDTH-1:0] word_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    logic  valid_in = 1'b0;
    logic  credit_in = 1'b0;
    logic  done = 1'b0;
    word_t data_in = '0;
    logic  credit_out, valid_out;
    word_t data_out;

    ff_stage #(
        .DEPTH   (DEPTH),
        .CREDITS (CREDITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .credit_in  (credit_in),
        .data_in    (data_in),
        .done       (done),
        .credit_out (credit_out),
        .data_out   (data_out),
        .valid_out  (valid_out)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fails     = 0;
    int ucred     = 0;

    // Behavioural model: queue of words held in the stage plus a downstream credit count.
    word_t mq[$];
    word_t mt[$];
    int    mcnt = CREDITS;
    logic  exp_valid = 1'b0;
    logic  exp_credit = 1'b0;
    word_t exp_data = '0;

    task automatic chk(input string name, input word_t act, input word_t exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task model_reset();
        mq.delete();
        mcnt       = CREDITS;
        exp_valid  = 1'b0;
        exp_credit = 1'b0;
        exp_data   = '0;
    endtask

    // Next-edge outcome from the current inputs: enqueue, send the oldest, drop overflow.
    task model_update();
        logic send;
        if (!rst || !done) begin
            model_reset();
            return;
        end
        send = ((mq.size() > 0) || valid_in) && (mcnt > 0);
        mt = mq;
        if (valid_in) mt.push_back(data_in);
        if (send) exp_data = mt.pop_front();
        if (mt.size() > int'(DEPTH)) mt.delete(mt.size() - 1);
        mq         = mt;
        exp_valid  = send;
        exp_credit = send;
        mcnt       = mcnt - (send ? 1 : 0) + (credit_in ? 1 : 0);
        if (mcnt > int'(CREDITS)) mcnt = CREDITS;
    endtask

    task compare_all();
        chk("valid_out",  word_t'(valid_out),  word_t'(exp_valid));
        chk("credit_out", word_t'(credit_out), word_t'(exp_credit));
        chk("data_out",   data_out,            exp_data);
        chk("credit_cnt", word_t'(dut.cnt_q),  word_t'(mcnt));
        chk("fifo_occ",   word_t'(dut.u_fifo.cnt_q), word_t'(mq.size()));
    endtask

    // Drive inputs just after a negedge, let one edge pass, check at the following negedge.
    task step(input logic vi, input logic ci, input word_t d, input logic dn);
        valid_in  = vi;
        credit_in = ci;
        data_in   = d;
        done      = dn;
        model_update();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_valid",  word_t'(valid_out),  '0);
        chk("rst_credit", word_t'(credit_out), '0);
        chk("rst_data",   data_out,            '0);
        chk("rst_cnt",    word_t'(dut.cnt_q),  word_t'(CREDITS));
        rst = 1'b1;

        // Empty stage with credit: one-cycle bypass latency.
        step(1'b1, 1'b1, 64'hDEADBEEF, 1'b1);
        chk("bypass_data",   data_out,            64'hDEADBEEF);
        chk("bypass_valid",  word_t'(valid_out),  64'd1);
        chk("bypass_credit", word_t'(credit_out), 64'd1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Exhaust credits: A, B go, C waits for a returned credit.
        step(1'b1, 1'b0, 64'hA, 1'b1);
        chk("exh_A", data_out, 64'hA);
        step(1'b1, 1'b0, 64'hB, 1'b1);
        chk("exh_B", data_out, 64'hB);
        step(1'b1, 1'b0, 64'hC, 1'b1);
        chk("exh_C_held_valid", word_t'(valid_out), 64'd0);
        chk("exh_data_holds",   data_out,           64'hB);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("exh_still_held", word_t'(valid_out), 64'd0);
        step(1'b0, 1'b1, '0, 1'b1);
        chk("exh_credit_edge", word_t'(valid_out), 64'd0);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("exh_C_valid", word_t'(valid_out), 64'd1);
        chk("exh_C_data",  data_out,           64'hC);

        // Ordering: queued X leaves before concurrent Y.
        step(1'b1, 1'b0, 64'h1111, 1'b1);
        step(1'b0, 1'b1, '0, 1'b1);
        step(1'b1, 1'b0, 64'h2222, 1'b1);
        chk("order_X_first", data_out, 64'h1111);
        step(1'b0, 1'b1, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("order_Y_second", data_out, 64'h2222);

        // cnt=1 with credit_in on every send sustains back-to-back traffic.
        step(1'b0, 1'b1, '0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, word_t'(64'h100 + i), 1'b1);
            chk("b2b_valid", word_t'(valid_out), 64'd1);
            chk("b2b_data",  data_out,           word_t'(64'h100 + i));
            chk("b2b_cnt",   word_t'(dut.cnt_q), 64'd1);
        end

        // Soft clear with two entries queued.
        step(1'b1, 1'b0, 64'h50, 1'b1);
        step(1'b1, 1'b0, 64'h51, 1'b1);
        step(1'b1, 1'b0, 64'h52, 1'b1);
        chk("clr_pre_occ", word_t'(dut.u_fifo.cnt_q), 64'd2);
        step(1'b1, 1'b1, 64'h53, 1'b0);
        chk("clr_valid", word_t'(valid_out),           64'd0);
        chk("clr_data",  data_out,                     64'd0);
        chk("clr_cnt",   word_t'(dut.cnt_q),           word_t'(CREDITS));
        chk("clr_occ",   word_t'(dut.u_fifo.cnt_q),    64'd0);
        step(1'b1, 1'b0, 64'h54, 1'b1);
        chk("clr_resume", data_out, 64'h54);

        // Asynchronous reset in the middle of a cycle.
        step(1'b1, 1'b0, 64'h77, 1'b1);
        chk("ar_pre_valid", word_t'(valid_out), 64'd1);
        @(posedge clk);
        #2;
        valid_in = 1'b0;
        rst = 1'b0;
        #1;
        chk("ar_valid",  word_t'(valid_out),  64'd0);
        chk("ar_credit", word_t'(credit_out), 64'd0);
        chk("ar_data",   data_out,            64'd0);
        model_reset();
        @(negedge clk);
        compare_all();
        rst = 1'b1;
        step(1'b0, 1'b0, '0, 1'b1);

        // Random traffic; upstream only pushes while it holds a credit.
        ucred = DEPTH;
        for (int i = 0; i < 3000; i++) begin
            logic  vi, ci, dn;
            word_t d;
            dn = ($urandom_range(0, 63) != 0);
            vi = dn && (ucred > 0) && ($urandom_range(0, 3) != 0);
            ci = ($urandom_range(0, 1) != 0);
            d  = {$urandom, $urandom};
            if (vi) ucred--;
            step(vi, ci, d, dn);
            if (!dn) ucred = DEPTH;
            else if (credit_out) ucred++;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
